fft_frame_arbiter: RTL

Shares one serialized FFT pipeline (deserializer -> FFT -> serializer, word-serial val/rdy on both sides) between two word-serial sample streams (channel 0, channel 1).
- Grants whole frames of N_SAMPLES words, round-robin, never interleaving channels within a frame.
- Records the channel ID of every frame in flight and steers each returning result frame to its owning channel's output.
- Sits between the two front-end sample sources and the FFT harness ports.

---
 rtl/fft_frame_arb_pkg.sv | 6 +
 rtl/fft_frame_arb_tag_fifo.sv | 47 ++++
 rtl/fft_frame_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/fft_frame_arb_pkg.sv
// fft_frame_arb_pkg: shared types and constants for the FFT frame arbiter.
package fft_frame_arb_pkg;
  localparam int NUM_CH = 2;
  typedef logic chan_id_t;
  typedef enum logic {IDLE, STREAM} in_state_t;
endpackage

// File: rtl/fft_frame_arb_tag_fifo.sv
// fft_frame_arb_tag_fifo: channel-ID FIFO tracking frames in flight through the FFT.
module fft_frame_arb_tag_fifo
  import fft_frame_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  chan_id_t      push_id,
  input  logic          pop,
  output chan_id_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  chan_id_t r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is fine then
  assign w_push = push && (!full || w_pop);
  assign full   = r_count == CW'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign head   = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_id;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop) r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: frame-granular two-channel arbiter in front of a shared FFT pipeline.
// Define FFT_FRAME_ARB_STRICT_PRIO_EN for fixed channel-0 priority instead of round-robin.
module fft_frame_arbiter
  import fft_frame_arb_pkg::*;
#(
  parameter int BIT_WIDTH       = 32,
  parameter int N_SAMPLES       = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [BIT_WIDTH-1:0]                   recv0_msg,
  input  logic                                   recv0_val,
  output logic                                   recv0_rdy,
  input  logic [BIT_WIDTH-1:0]                   recv1_msg,
  input  logic                                   recv1_val,
  output logic                                   recv1_rdy,
  output logic [BIT_WIDTH-1:0]                   fft_recv_msg,
  output logic                                   fft_recv_val,
  input  logic                                   fft_recv_rdy,
  input  logic [BIT_WIDTH-1:0]                   fft_send_msg,
  input  logic                                   fft_send_val,
  output logic                                   fft_send_rdy,
  output logic [BIT_WIDTH-1:0]                   send0_msg,
  output logic                                   send0_val,
  input  logic                                   send0_rdy,
  output logic [BIT_WIDTH-1:0]                   send1_msg,
  output logic                                   send1_val,
  input  logic                                   send1_rdy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   in_flight,
  output logic                                   busy
);
  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);
  in_state_t r_state, w_state_nxt;
  chan_id_t r_grant, w_win, w_head;
  logic [CNT_W-1:0] r_in_cnt, r_out_cnt;
  logic w_stream, w_full, w_empty, w_grant, w_pop, w_in_fire, w_last_in, w_out_fire;
`ifdef FFT_FRAME_ARB_STRICT_PRIO_EN
  assign w_win = !recv0_val;
`else
  chan_id_t r_ptr;
  assign w_win = (recv0_val && recv1_val) ? r_ptr : recv1_val;
`endif
  assign w_stream     = r_state == STREAM;
  assign fft_recv_msg = r_grant ? recv1_msg : recv0_msg;
  assign fft_recv_val = w_stream && (r_grant ? recv1_val : recv0_val);
  assign recv0_rdy    = w_stream && !r_grant && fft_recv_rdy;
  assign recv1_rdy    = w_stream && r_grant && fft_recv_rdy;
  assign w_in_fire    = fft_recv_val && fft_recv_rdy;
  assign w_last_in    = w_in_fire && r_in_cnt == LAST;
  assign send0_msg    = fft_send_msg;
  assign send1_msg    = fft_send_msg;
  assign send0_val    = !w_empty && !w_head && fft_send_val;
  assign send1_val    = !w_empty && w_head && fft_send_val;
  assign fft_send_rdy = !w_empty && (w_head ? send1_rdy : send0_rdy);
  assign w_out_fire   = fft_send_val && fft_send_rdy;
  assign w_pop        = w_out_fire && r_out_cnt == LAST;
  // the final returning word frees a tag slot in time for a grant on the same edge
  assign w_grant      = !w_stream && (recv0_val || recv1_val) && (!w_full || w_pop);
  assign busy         = in_flight != '0 || w_stream;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_stream ? (w_last_in ? IDLE : STREAM) : (w_grant ? STREAM : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_grant <= w_win;
      if (w_in_fire) r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
      if (w_out_fire) r_out_cnt <= w_pop ? '0 : r_out_cnt + 1'b1;
    end
  end
`ifndef FFT_FRAME_ARB_STRICT_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) r_ptr <= 1'b0;
    else if (w_last_in) r_ptr <= !r_grant;
  end
`endif
  fft_frame_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
    .clk     (clk),
    .reset   (reset),
    .push    (w_grant),
    .push_id (w_win),
    .pop     (w_pop),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (in_flight)
  );
endmodule
